// File: rtl/uart_tx_sched_if.sv
// ----------------------------------------------------------------------------
// uart_tx_sched_if
//   Byte-request handshake between two requesters and the UART TX scheduler.
//
//   req0 / req1   : level requests, held until the matching ack pulse
//   data0 / data1 : request payload, stable while the request is high
//   ack0 / ack1   : one-clk acceptance pulse from the scheduler
//
//   master : requester side (drives req/data, receives ack)
//   slave  : scheduler side (receives req/data, drives ack)
// ----------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int DATA_W = 8
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              ack1;

    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1
    );

    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1
    );
endinterface

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
//   Two-requester round-robin transmit scheduler and 8N1/8N2 serializer.
//   The winning byte is framed (start, DATA_W data bits LSB first, STOP_BITS
//   stop bits) and shifted out one bit per baud tick. The baud generator's
//   rate select is only updated while idle, so a frame never changes rate.
//
//   clk      : system clock
//   n_rst    : asynchronous active-low reset
//   txen     : one-clk baud tick from the baud enable generator
//   sel_req  : requested baud rate (0 = 9600, 1 = 19200)
//   sel      : rate select to the baud enable generator (frozen mid-frame)
//   bus      : request/data/ack handshake for requesters 0 and 1
//   tx       : serial line, idle high
//   busy     : high from grant through the end of the last stop bit
//   gnt_id   : id of the current or most recent grant
// ----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           txen,
    input  logic           sel_req,
    output logic           sel,
    uart_tx_sched_if.slave bus,
    output logic           tx,
    output logic           busy,
    output logic           gnt_id
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_stop_cnt;
    logic              r_tx;
    logic              r_busy;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_sel;
    logic              r_gnt_id;
    logic              r_last;      // id of the last winner; 1 at reset so requester 0 wins the first tie

    logic              w_grant0;
    logic              w_grant1;

    // On a tie the requester that did not win last time is served.
    assign w_grant0 = bus.req0 && (!bus.req1 || r_last);
    assign w_grant1 = bus.req1 && (!bus.req0 || !r_last);

    // NOTE: every state register, including the shift register, sits in the
    // async reset list so a mid-frame reset drops the byte and idles the line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_sel      <= 1'b0;
            r_gnt_id   <= 1'b0;
            r_last     <= 1'b1;
        end else begin
            // NOTE: non-blocking throughout; the ack defaults low here and is
            // overridden only in the grant cycle, giving a one-clk pulse.
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_sel <= sel_req;
                    if (w_grant0 || w_grant1) begin
                        r_shift  <= w_grant1 ? bus.data1 : bus.data0;
                        r_gnt_id <= w_grant1;
                        r_last   <= w_grant1;
                        r_ack0   <= w_grant0;
                        r_ack1   <= w_grant1;
                        r_busy   <= 1'b1;
                        r_state  <= S_SYNC;
                    end
                end

                // Start bit begins on a tick edge so every bit is a full tick period.
                S_SYNC: begin
                    if (txen) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (txen) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end

                // r_bit_cnt is the index of the bit currently on the line.
                S_DATA: begin
                    if (txen) begin
                        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                S_STOP: begin
                    if (txen) begin
                        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign sel      = r_sel;
    assign gnt_id   = r_gnt_id;
    assign bus.ack0 = r_ack0;
    assign bus.ack1 = r_ack1;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Scoreboard bench for uart_tx_sched. Stimulus pushes expected frames and
//   expected ack ids into queues; independent monitors decode the serial line
//   and the ack pulses and compare against the queue heads.
//   Two instances: dut (8N1) and dut_b (8N2); the monitors watch one of them
//   at a time through a small mux selected by m_sel.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int DATA_W  = 8;
    localparam int BIT_CLK = 4;     // txen period in clocks

    typedef struct packed {
        logic [7:0] data;
        logic       id;
    } exp_t;

    logic clk     = 1'b0;
    logic n_rst   = 1'b1;
    logic txen    = 1'b0;
    logic sel_req = 1'b0;

    logic tx_a, busy_a, gnt_a, sel_a;
    logic tx_b, busy_b, gnt_b, sel_b;

    uart_tx_sched_if #(.DATA_W(DATA_W)) bus_a ();
    uart_tx_sched_if #(.DATA_W(DATA_W)) bus_b ();

    uart_tx_sched #(.DATA_W(DATA_W), .STOP_BITS(1)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .txen    (txen),
        .sel_req (sel_req),
        .sel     (sel_a),
        .bus     (bus_a),
        .tx      (tx_a),
        .busy    (busy_a),
        .gnt_id  (gnt_a)
    );

    uart_tx_sched #(.DATA_W(DATA_W), .STOP_BITS(2)) dut_b (
        .clk     (clk),
        .n_rst   (n_rst),
        .txen    (txen),
        .sel_req (sel_req),
        .sel     (sel_b),
        .bus     (bus_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .gnt_id  (gnt_b)
    );

    always #5 clk = ~clk;

    // Monitor view: 0 watches dut, 1 watches dut_b.
    logic m_sel = 1'b0;
    logic m_tx, m_busy, m_gnt, m_ack0, m_ack1;
    assign m_tx   = m_sel ? tx_b       : tx_a;
    assign m_busy = m_sel ? busy_b     : busy_a;
    assign m_gnt  = m_sel ? gnt_b      : gnt_a;
    assign m_ack0 = m_sel ? bus_b.ack0 : bus_a.ack0;
    assign m_ack1 = m_sel ? bus_b.ack1 : bus_a.ack1;

    exp_t frame_q[$];
    logic ack_q[$];

    int   n_vec      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   ack_cnt    = 0;
    int   prev_start = 0;
    int   last_start = 0;
    int   txen_ph    = 0;
    logic mon_prev_tx;
    logic ack_eid;
    logic sel_seen;
    int   loop_n;

    always @(posedge clk) cyc <= cyc + 1;

    // Baud tick: one-clk pulse every BIT_CLK clocks, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            txen    = (txen_ph == 0);
            txen_ph = (txen_ph + 1) % BIT_CLK;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no such event, want the event within its budget (cycle %0d)", name, cyc);
    endtask

    // Called at the first falling-edge sample of a start bit.
    task automatic decode_frame();
        logic [DATA_W-1:0] bits;
        logic start_ok, stable_ok, stop_ok, id_seen;
        int   nstop;
        exp_t e;
        bits       = '0;
        start_ok   = 1'b1;
        stable_ok  = 1'b1;
        stop_ok    = 1'b1;
        id_seen    = m_gnt;
        nstop      = m_sel ? 2 : 1;
        prev_start = last_start;
        last_start = cyc;
        repeat (BIT_CLK - 1) begin
            @(negedge clk);
            if (!n_rst) return;
            if (m_tx !== 1'b0) start_ok = 1'b0;
        end
        for (int b = 0; b < DATA_W; b++) begin
            for (int s = 0; s < BIT_CLK; s++) begin
                @(negedge clk);
                if (!n_rst) return;
                if (s == 0) bits[b] = m_tx;
                else if (m_tx !== bits[b]) stable_ok = 1'b0;
            end
        end
        repeat (BIT_CLK * nstop) begin
            @(negedge clk);
            if (!n_rst) return;
            if (m_tx !== 1'b1) stop_ok = 1'b0;
        end
        @(negedge clk);
        if (!n_rst) return;
        check("start_bit_width", start_ok, 1);
        check("data_bit_width", stable_ok, 1);
        check("stop_bits_high", stop_ok, 1);
        check("busy_low_after_stop", m_busy, 0);
        if (frame_q.size() == 0) begin
            fail("unexpected_frame");
        end else begin
            e = frame_q.pop_front();
            check("frame_data", bits, e.data);
            check("frame_gnt_id", id_seen, e.id);
        end
    endtask

    // Frame monitor: a high-to-low transition on the line opens a frame.
    initial begin
        mon_prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                mon_prev_tx = 1'b1;
            end else if (mon_prev_tx && !m_tx) begin
                decode_frame();
                mon_prev_tx = 1'b1;
            end else begin
                mon_prev_tx = m_tx;
            end
        end
    end

    // Ack monitor: each pulse is matched to the next expected requester id.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst && (m_ack0 || m_ack1)) begin
                ack_cnt++;
                if (ack_q.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    ack_eid = ack_q.pop_front();
                    check("ack0_level", m_ack0, !ack_eid);
                    check("ack1_level", m_ack1, ack_eid);
                    check("ack_gnt_id", m_gnt, ack_eid);
                end
                @(negedge clk);
                if (n_rst) begin
                    check("ack0_one_clk", m_ack0, 0);
                    check("ack1_one_clk", m_ack1, 0);
                end
            end
        end
    end

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (ack_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (ack_cnt < target) fail(name);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!(m_tx === 1'b0 && m_busy === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail(name);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((frame_q.size() != 0 || ack_q.size() != 0 || m_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail(name);
        repeat (3) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic id);
        exp_t e;
        e.data = d;
        e.id   = id;
        frame_q.push_back(e);
        ack_q.push_back(id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want finish before 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.data0 = '0; bus_a.data1 = '0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.data0 = '0; bus_b.data1 = '0;

        // Reset values while reset is held.
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_gnt_id", gnt_a, 0);
        check("rst_sel", sel_a, 0);
        check("rst_ack0", bus_a.ack0, 0);
        check("rst_ack1", bus_a.ack1, 0);
        check("rst_b_tx", tx_b, 1);
        n_rst = 1'b1;

        // Idle, no requests: sel follows sel_req, line stays high.
        sel_req = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sel_tracks_1", sel_a, 1);
        sel_req = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sel_tracks_0", sel_a, 0);
        repeat (16) @(negedge clk);
        check("idle_tx_high", tx_a, 1);
        check("idle_busy_low", busy_a, 0);
        check("idle_no_ack", ack_cnt, 0);

        // Both requesters held: grants alternate 0,1,0,1.
        bus_a.data0 = 8'h11;
        bus_a.data1 = 8'h22;
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        bus_a.req0 = 1'b1;
        bus_a.req1 = 1'b1;
        wait_acks(ack_cnt + 4, "rr_four_acks");
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        wait_drain("rr_drain");

        // Single request, 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        bus_a.data0 = 8'hA5;
        push(8'hA5, 1'b0);
        bus_a.req0 = 1'b1;
        wait_acks(ack_cnt + 1, "a5_ack");
        bus_a.req0 = 1'b0;
        wait_drain("a5_drain");

        // sel_req raised mid-frame: sel holds until one cycle after busy falls.
        bus_a.data0 = 8'h0F;
        push(8'h0F, 1'b0);
        bus_a.req0 = 1'b1;
        wait_acks(ack_cnt + 1, "sel_ack");
        bus_a.req0 = 1'b0;
        repeat (8) @(negedge clk);
        sel_req  = 1'b1;
        sel_seen = 1'b0;
        loop_n   = 0;
        while (busy_a && loop_n < 400) begin
            if (sel_a) sel_seen = 1'b1;
            @(negedge clk);
            loop_n++;
        end
        check("sel_busy_fell", busy_a, 0);
        check("sel_frozen_in_frame", sel_seen, 0);
        check("sel_at_busy_fall", sel_a, 0);
        @(negedge clk);
        check("sel_one_cycle_later", sel_a, 1);
        wait_drain("sel_drain");
        sel_req = 1'b0;
        repeat (2) @(negedge clk);

        // 8N2 instance, 0xFF back to back: 11 bit periods + 1 SYNC period between starts.
        m_sel = 1'b1;
        bus_b.data0 = 8'hFF;
        push(8'hFF, 1'b0);
        push(8'hFF, 1'b0);
        bus_b.req0 = 1'b1;
        wait_acks(ack_cnt + 2, "stop2_acks");
        bus_b.req0 = 1'b0;
        wait_drain("stop2_drain");
        check("stop2_start_to_start", last_start - prev_start, 48);
        m_sel = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during data bit 3; the held request is re-served afterwards.
        bus_a.data1 = 8'h3C;
        push(8'h3C, 1'b1);
        ack_q.push_back(1'b1);
        bus_a.req1 = 1'b1;
        wait_acks(ack_cnt + 1, "rst_first_ack");
        wait_start("rst_frame_start");
        repeat (17) @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("rst_mid_tx_async", tx_a, 1);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_gnt_id", gnt_a, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        wait_acks(ack_cnt + 1, "rst_fresh_ack");
        bus_a.req1 = 1'b0;
        wait_drain("rst_drain");

        check("frames_left", frame_q.size(), 0);
        check("acks_left", ack_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
